// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and small decode helpers.
package program_loader_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        LdrIdle = 3'd0,
        LdrLen  = 3'd1,
        LdrWait = 3'd2,
        LdrAddr = 3'd3,
        LdrData = 3'd4,
        LdrDone = 3'd5
    } ldr_state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_stream(input ldr_state_e st);
        return (st == LdrLen) || (st == LdrWait);
    endfunction

    // States in which the loader owns the shared bus.
    function automatic logic drives_bus(input ldr_state_e st);
        return (st == LdrAddr) || (st == LdrData);
    endfunction

endpackage

// File: rtl/program_loader_counter.sv
// Loadable up-counter used as the RAM address generator; load has priority over increment.
module program_loader_counter #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         inc_i,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + N'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/program_loader.sv
// Bus-master loader: takes a length-prefixed byte stream and writes it to RAM via MAR/RAM strobes,
// holding the CPU in reset for the duration of the load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] BASE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       c_mi,
    output logic       c_ri,
    output logic       cpu_hold,
    output logic       done,
    output logic [7:0] checksum
);

    ldr_state_e state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] checksum_q, checksum_d;
    logic [7:0] addr;
    logic       addr_load;
    logic       addr_inc;
    logic       xfer;

    program_loader_counter #(
        .N(8)
    ) u_addr (
        .clk_i     (clk),
        .rst_i     (reset),
        .load_i    (addr_load),
        .load_val_i(BASE),
        .inc_i     (addr_inc),
        .count_o   (addr)
    );

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        byte_d      = byte_q;
        checksum_d  = checksum_q;
        addr_load   = 1'b0;
        addr_inc    = 1'b0;
        unique case (state_q)
            LdrIdle: begin
                if (start) begin
                    state_d    = LdrLen;
                    checksum_d = 8'h00;
                    addr_load  = 1'b1;
                end
            end
            LdrLen: begin
                if (xfer) begin
                    remaining_d = in_data;
                    state_d     = (in_data == 8'h00) ? LdrDone : LdrWait;
                end
            end
            LdrWait: begin
                if (xfer) begin
                    byte_d     = in_data;
                    checksum_d = checksum_q + in_data;
                    state_d    = LdrAddr;
                end
            end
            LdrAddr: begin
                state_d = LdrData;
            end
            LdrData: begin
                addr_inc    = 1'b1;
                remaining_d = remaining_q - 8'd1;
                state_d     = (remaining_q == 8'd1) ? LdrDone : LdrWait;
            end
            LdrDone: begin
                state_d = LdrIdle;
            end
            default: begin
                state_d = LdrIdle;
            end
        endcase
    end

    // Every strobe is a pure decode of the state register, so an async reset kills it at once.
    always_comb begin
        in_ready = accepts_stream(state_q);
        bus_oe   = drives_bus(state_q);
        c_mi     = (state_q == LdrAddr);
        c_ri     = (state_q == LdrData);
        cpu_hold = (state_q != LdrIdle);
        done     = (state_q == LdrDone);
        bus_out  = 8'h00;
        if (state_q == LdrAddr) begin
            bus_out = addr;
        end else if (state_q == LdrData) begin
            bus_out = byte_q;
        end
        checksum = checksum_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LdrIdle;
            remaining_q <= 8'h00;
            byte_q      <= 8'h00;
            checksum_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            byte_q      <= byte_d;
            checksum_q  <= checksum_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (BASE 00 and FE) share the stream inputs and each
// drives its own RAM model; results are checked against a spec-level memory image and checksum.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [7:0] in_data;
    logic       in_valid;
    logic [1:0] in_ready, bus_oe, c_mi, c_ri, cpu_hold, done;
    logic [7:0] bus_out [2];
    logic [7:0] checksum [2];

    int total = 0;
    int bad   = 0;

    logic [7:0] mar [2];
    logic [7:0] ram [2][256];
    logic [7:0] exp_mem [2][256];
    int n_mi [2];
    int n_ri [2];
    int n_done [2];
    int n_proto [2];

    always #5 clk = ~clk;

    program_loader #(.BASE(8'h00)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .c_mi(c_mi[0]),
        .c_ri(c_ri[0]), .cpu_hold(cpu_hold[0]), .done(done[0]), .checksum(checksum[0])
    );

    program_loader #(.BASE(8'hFE)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .c_mi(c_mi[1]),
        .c_ri(c_ri[1]), .cpu_hold(cpu_hold[1]), .done(done[1]), .checksum(checksum[1])
    );

    // MAR/RAM model on the shared bus, plus strobe bookkeeping.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if ((c_mi[s] && c_ri[s]) || ((c_mi[s] || c_ri[s]) !== bus_oe[s]) ||
                (bus_oe[s] && !cpu_hold[s])) n_proto[s]++;
            if (c_mi[s] === 1'b1) begin
                mar[s] = bus_out[s];
                n_mi[s]++;
            end
            if (c_ri[s] === 1'b1) begin
                ram[s][mar[s]] = bus_out[s];
                n_ri[s]++;
            end
            if (done[s] === 1'b1) n_done[s]++;
        end
    end

    function automatic logic [7:0] base_of(input int s);
        return (s == 1) ? 8'hFE : 8'h00;
    endfunction

    function automatic int ram_diffs(input int s);
        int d = 0;
        for (int i = 0; i < 256; i++) if (ram[s][i] !== exp_mem[s][i]) d++;
        return d;
    endfunction

    task automatic clear_counts(input int s);
        n_mi[s] = 0;
        n_ri[s] = 0;
        n_done[s] = 0;
        n_proto[s] = 0;
    endtask

    // Entered and left just after a negedge; the byte is taken at the posedge in between.
    task automatic send_byte(input int s, input logic [7:0] b, input int gap, input bit hold,
                             output bit ok);
        if (!hold) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready[s] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_byte inst%0d: in_ready never rose, got=0 want=1", s);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic run_load(input int s, input logic [7:0] pl[$], input int gap_max,
                            input bit hold, input bit collide, input bit poke, input string tag);
        logic [7:0] sum = 8'h00;
        logic [7:0] a;
        int len = pl.size();
        bit ok, found;
        foreach (pl[i]) begin
            sum = sum + pl[i];
            a = base_of(s) + 8'(i);
            exp_mem[s][a] = pl[i];
        end
        clear_counts(s);
        @(negedge clk);
        start[s] = 1'b1;
        if (collide) begin
            in_valid = 1'b1;
            in_data  = 8'hC3;
            total++;
            if (in_ready[s] !== 1'b0) begin
                bad++;
                $display("FAIL %s idle_ready got=%b want=0", tag, in_ready[s]);
            end
        end
        @(negedge clk);
        start[s] = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready[s] !== 1'b1 || cpu_hold[s] !== 1'b1) begin
            bad++;
            $display("FAIL %s len_state got ready=%b hold=%b want 1 1", tag, in_ready[s],
                     cpu_hold[s]);
        end
        send_byte(s, 8'(len), 0, hold, ok);
        for (int i = 0; i < len; i++) begin
            send_byte(s, pl[i], $urandom_range(0, gap_max), hold, ok);
            if (poke && i == 0) begin
                @(negedge clk);
                start[s] = 1'b1;
                @(negedge clk);
                start[s] = 1'b0;
            end
        end
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done[s] === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s done_seen got=0 want=1", tag);
        end
        total++;
        if (cpu_hold[s] !== 1'b1) begin
            bad++;
            $display("FAIL %s hold_during_done got=%b want=1", tag, cpu_hold[s]);
        end
        @(negedge clk);
        total++;
        if (done[s] !== 1'b0 || cpu_hold[s] !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got done=%b hold=%b want 0 0", tag, done[s], cpu_hold[s]);
        end
        total++;
        if (checksum[s] !== sum) begin
            bad++;
            $display("FAIL %s checksum got=%h want=%h", tag, checksum[s], sum);
        end
        total++;
        if (n_ri[s] != len || n_mi[s] != len) begin
            bad++;
            $display("FAIL %s strobes got mi=%0d ri=%0d want=%0d", tag, n_mi[s], n_ri[s], len);
        end
        total++;
        if (n_done[s] != 1) begin
            bad++;
            $display("FAIL %s done_cycles got=%0d want=1", tag, n_done[s]);
        end
        total++;
        if (n_proto[s] != 0) begin
            bad++;
            $display("FAIL %s strobe_overlap got=%0d want=0", tag, n_proto[s]);
        end
        total++;
        if (ram_diffs(s) != 0) begin
            bad++;
            $display("FAIL %s ram got=%0d bad bytes want=0", tag, ram_diffs(s));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if ({in_ready[s], bus_oe[s], c_mi[s], c_ri[s], cpu_hold[s], done[s]} !== 6'b0 ||
                bus_out[s] !== 8'h00 || checksum[s] !== 8'h00) begin
                bad++;
                $display("FAIL reset inst%0d got ctl=%b bus=%h sum=%h want all zero", s,
                         {in_ready[s], bus_oe[s], c_mi[s], c_ri[s], cpu_hold[s], done[s]},
                         bus_out[s], checksum[s]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] q[$] = '{8'h11, 8'h22, 8'h33};
        run_load(0, q, 0, 1'b1, 1'b0, 1'b0, "basic");
        total++;
        if (checksum[0] !== 8'h66) begin
            bad++;
            $display("FAIL basic_sum66 got=%h want=66", checksum[0]);
        end
    endtask

    task automatic test_empty();
        logic [7:0] q[$];
        run_load(0, q, 0, 1'b0, 1'b0, 1'b0, "empty");
    endtask

    task automatic test_wrap();
        logic [7:0] q[$] = '{8'hAA, 8'hBB, 8'hCC};
        run_load(1, q, 1, 1'b0, 1'b0, 1'b0, "wrap");
        total++;
        if (ram[1][8'hFE] !== 8'hAA || ram[1][8'hFF] !== 8'hBB || ram[1][8'h00] !== 8'hCC ||
            checksum[1] !== 8'h31) begin
            bad++;
            $display("FAIL wrap_image got=%h %h %h sum=%h want=aa bb cc 31", ram[1][8'hFE],
                     ram[1][8'hFF], ram[1][8'h00], checksum[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1, b2;
        logic [7:0] q[$] = '{8'h5A};
        bit ok;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        clear_counts(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        send_byte(0, 8'd3, 0, 1'b0, ok);
        send_byte(0, b1, 0, 1'b0, ok);
        send_byte(0, b2, 0, 1'b0, ok);
        @(negedge clk);
        total++;
        if (c_ri[0] !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_data got c_ri=%b want=1", c_ri[0]);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (c_ri[0] !== 1'b0 || bus_oe[0] !== 1'b0 || cpu_hold[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got ri=%b oe=%b hold=%b want 0 0 0", c_ri[0], bus_oe[0],
                     cpu_hold[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_mem[0][8'h00] = b1;
        total++;
        if (n_done[0] != 0 || n_ri[0] != 1) begin
            bad++;
            $display("FAIL rstmid_counts got done=%0d ri=%0d want 0 1", n_done[0], n_ri[0]);
        end
        total++;
        if (ram_diffs(0) != 0) begin
            bad++;
            $display("FAIL rstmid_ram got=%0d bad bytes want=0", ram_diffs(0));
        end
        run_load(0, q, 0, 1'b0, 1'b0, 1'b0, "after_rst");
    endtask

    // Per-byte phase timing with two idle stream cycles between bytes.
    task automatic test_stall();
        logic [7:0] pl [3];
        logic [7:0] sum = 8'h00;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            pl[i] = 8'($urandom);
            sum = sum + pl[i];
            exp_mem[0][i] = pl[i];
        end
        clear_counts(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        send_byte(0, 8'd3, 0, 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            send_byte(0, pl[i], 0, 1'b0, ok);
            total++;
            if ({c_mi[0], c_ri[0], bus_oe[0], in_ready[0]} !== 4'b1010 || bus_out[0] !== 8'(i)) begin
                bad++;
                $display("FAIL stall_addr got mi/ri/oe/rdy=%b bus=%h want 1010 %h",
                         {c_mi[0], c_ri[0], bus_oe[0], in_ready[0]}, bus_out[0], 8'(i));
            end
            @(negedge clk);
            total++;
            if ({c_mi[0], c_ri[0], bus_oe[0]} !== 3'b011 || bus_out[0] !== pl[i]) begin
                bad++;
                $display("FAIL stall_data got mi/ri/oe=%b bus=%h want 011 %h",
                         {c_mi[0], c_ri[0], bus_oe[0]}, bus_out[0], pl[i]);
            end
            @(negedge clk);
            if (i < 2) begin
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if ({in_ready[0], bus_oe[0], c_mi[0], c_ri[0]} !== 4'b1000) begin
                        bad++;
                        $display("FAIL stall_wait got rdy/oe/mi/ri=%b want=1000",
                                 {in_ready[0], bus_oe[0], c_mi[0], c_ri[0]});
                    end
                    @(negedge clk);
                end
            end else begin
                total++;
                if (done[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_done got=%b want=1", done[0]);
                end
            end
        end
        @(negedge clk);
        total++;
        if (checksum[0] !== sum || cpu_hold[0] !== 1'b0 || n_ri[0] != 3) begin
            bad++;
            $display("FAIL stall_end got sum=%h hold=%b ri=%0d want %h 0 3", checksum[0],
                     cpu_hold[0], n_ri[0], sum);
        end
        total++;
        if (ram_diffs(0) != 0) begin
            bad++;
            $display("FAIL stall_ram got=%0d bad bytes want=0", ram_diffs(0));
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] q[$];
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        run_load(0, q, 1, 1'b0, 1'b1, 1'b1, "start_ign");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [7:0] q[$];
            int s = $urandom_range(0, 1);
            int len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_load(s, q, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_long_wrap();
        logic [7:0] q[$];
        for (int i = 0; i < 255; i++) q.push_back(8'($urandom));
        run_load(1, q, 0, 1'b1, 1'b0, 1'b0, "long255");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 2'b00;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int s = 0; s < 2; s++) begin
            mar[s] = 8'h00;
            clear_counts(s);
            for (int i = 0; i < 256; i++) begin
                ram[s][i] = 8'h00;
                exp_mem[s][i] = 8'h00;
            end
        end
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_reset_mid();
        test_stall();
        test_start_ignored();
        test_random();
        test_long_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
